// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: keypad geometry, scan FSM
// state encoding and the key-code map (code = row*4 + col).
package calc_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  localparam int KEY_W    = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  // Calculator legend printed on the keypad, indexed by row*4 + col.
  localparam logic [KEY_W-1:0] KEY_1   = 4'd0;
  localparam logic [KEY_W-1:0] KEY_2   = 4'd1;
  localparam logic [KEY_W-1:0] KEY_3   = 4'd2;
  localparam logic [KEY_W-1:0] KEY_ADD = 4'd3;
  localparam logic [KEY_W-1:0] KEY_4   = 4'd4;
  localparam logic [KEY_W-1:0] KEY_5   = 4'd5;
  localparam logic [KEY_W-1:0] KEY_6   = 4'd6;
  localparam logic [KEY_W-1:0] KEY_SUB = 4'd7;
  localparam logic [KEY_W-1:0] KEY_7   = 4'd8;
  localparam logic [KEY_W-1:0] KEY_8   = 4'd9;
  localparam logic [KEY_W-1:0] KEY_9   = 4'd10;
  localparam logic [KEY_W-1:0] KEY_MUL = 4'd11;
  localparam logic [KEY_W-1:0] KEY_CLR = 4'd12;
  localparam logic [KEY_W-1:0] KEY_0   = 4'd13;
  localparam logic [KEY_W-1:0] KEY_EQ  = 4'd14;
  localparam logic [KEY_W-1:0] KEY_DIV = 4'd15;

  // Lowest-numbered row that is pulled low wins when several keys share a column.
  function automatic logic [1:0] lowest_low_row(input logic [KEY_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int r = KEY_ROWS - 1; r >= 0; r--) begin
      if (!rows[r]) idx = r[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchroniser for the asynchronous keypad row lines; resets to
// all-high so an idle keypad (pull-ups) is seen during and after reset.
module keypad_sync2
  import calc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_ROWS-1:0] d,
  output logic [KEY_ROWS-1:0] q
);

  logic [KEY_ROWS-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: walks the columns, debounces one key at a time and
// hands each clean press to the calculator core over valid/ready.
module keypad_scan_ctrl
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_ROWS-1:0] row_in,
  output logic [KEY_COLS-1:0] col_out,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_held,
  output logic                overrun
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

  scan_state_t         state;
  logic [DW-1:0]       dwell;
  logic [BW-1:0]       deb_cnt;
  logic [1:0]          col_idx;
  logic [1:0]          row_idx;
  logic [KEY_ROWS-1:0] row_s;
  logic                row_low;
  logic                handshake;

  keypad_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_in),
    .q   (row_s)
  );

  assign col_out   = ~(4'b0001 << col_idx);
  assign row_low   = ~row_s[row_idx];
  assign handshake = key_valid & key_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      dwell     <= '0;
      deb_cnt   <= '0;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (handshake) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end

      case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (&row_s) begin
              col_idx <= col_idx + 2'd1;
            end else begin
              row_idx <= lowest_low_row(row_s);
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (row_low) begin
            if (deb_cnt == DEB_LAST) begin
              deb_cnt  <= '0;
              key_held <= 1'b1;
              state    <= HELD;
              // A pending code that is not being taken this cycle wins; the new press is dropped.
              if (!key_valid || key_ready) begin
                key_code  <= {row_idx, col_idx};
                key_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            state   <= SCAN;
          end
        end

        HELD: begin
          if (!row_low) begin
            if (deb_cnt == DEB_LAST) begin
              deb_cnt  <= '0;
              key_held <= 1'b0;
              dwell    <= '0;
              col_idx  <= col_idx + 2'd1;
              state    <= SCAN;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            deb_cnt <= '0;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: directed scenarios plus randomized
// presses on a modelled 4x4 key matrix checked against an expected-code queue.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_ready = 1'b0;
  logic [15:0] pressed = 16'h0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        overrun;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Physical key matrix: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (col_out !== 4'b1110) $display("FAIL reset_col: got %b expected 1110", col_out); else passed++;
    total++; if (key_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", key_valid); else passed++;
    total++; if (key_held !== 1'b0) $display("FAIL reset_held: got %b expected 0", key_held); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      total++;
      if (col_out !== exp_col) $display("FAIL rotate cycle %0d: got %b expected %b", k, col_out, exp_col);
      else passed++;
    end
    $display("test_reset done");
  endtask

  task automatic test_press_release();
    int k_valid = -1;
    int nvalid  = 0;
    logic [3:0] code_seen = 4'h0;
    bit col_ok = 1'b1;
    do_reset();
    key_ready = 1'b1;
    pressed = 16'h0;
    pressed[2*4+1] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (key_valid) begin
        if (k_valid < 0) begin
          k_valid = k;
          code_seen = key_code;
        end
        nvalid++;
      end
      if (key_held && col_out !== 4'b1101) col_ok = 1'b0;
    end
    total++; if (k_valid !== 16) $display("FAIL press_latency: got %0d expected 16", k_valid); else passed++;
    total++; if (nvalid !== 1) $display("FAIL valid_width: got %0d expected 1", nvalid); else passed++;
    total++; if (code_seen !== 4'h9) $display("FAIL press_code: got %h expected 9", code_seen); else passed++;
    total++; if (col_ok !== 1'b1) $display("FAIL col_frozen: got %b expected 1", col_ok); else passed++;
    total++; if (key_held !== 1'b1) $display("FAIL held_during: got %b expected 1", key_held); else passed++;
    pressed = 16'h0;
    repeat (9) @(negedge clk);
    total++; if (key_held !== 1'b1) $display("FAIL held_before_release: got %b expected 1", key_held); else passed++;
    @(negedge clk);
    total++; if (key_held !== 1'b0) $display("FAIL held_after_release: got %b expected 0", key_held); else passed++;
    total++; if (col_out !== 4'b1011) $display("FAIL col_after_release: got %b expected 1011", col_out); else passed++;
    $display("test_press_release done: valid at cycle %0d code %h", k_valid, code_seen);
  endtask

  task automatic test_bounce();
    bit saw_valid = 1'b0;
    bit saw_held  = 1'b0;
    do_reset();
    key_ready = 1'b1;
    pressed = 16'h0001;
    repeat (3) @(negedge clk);
    pressed = 16'h0;
    repeat (2) @(negedge clk);
    total++; if (col_out !== 4'b1110) $display("FAIL bounce_col_frozen: got %b expected 1110", col_out); else passed++;
    @(negedge clk);
    total++; if (col_out !== 4'b1101) $display("FAIL bounce_resume: got %b expected 1101", col_out); else passed++;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (key_valid) saw_valid = 1'b1;
      if (key_held) saw_held = 1'b1;
    end
    total++; if (saw_valid !== 1'b0) $display("FAIL bounce_valid: got %b expected 0", saw_valid); else passed++;
    total++; if (saw_held !== 1'b0) $display("FAIL bounce_held: got %b expected 0", saw_held); else passed++;
    $display("test_bounce done");
  endtask

  task automatic test_overrun();
    do_reset();
    key_ready = 1'b0;
    pressed = 16'h0;
    pressed[1*4+2] = 1'b1;
    for (int i = 0; i < 100 && !key_valid; i++) @(negedge clk);
    total++; if (key_valid !== 1'b1) $display("FAIL ovr_first_valid: got %b expected 1", key_valid); else passed++;
    total++; if (key_code !== 4'h6) $display("FAIL ovr_first_code: got %h expected 6", key_code); else passed++;
    pressed = 16'h0;
    for (int i = 0; i < 100 && key_held; i++) @(negedge clk);
    total++; if (key_held !== 1'b0) $display("FAIL ovr_release1: got %b expected 0", key_held); else passed++;
    pressed[3*4+3] = 1'b1;
    for (int i = 0; i < 100 && !key_held; i++) @(negedge clk);
    total++; if (key_held !== 1'b1) $display("FAIL ovr_second_held: got %b expected 1", key_held); else passed++;
    total++; if (key_code !== 4'h6) $display("FAIL ovr_code_kept: got %h expected 6", key_code); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b expected 1", overrun); else passed++;
    pressed = 16'h0;
    for (int i = 0; i < 100 && key_held; i++) @(negedge clk);
    total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b expected 1", overrun); else passed++;
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    total++; if (key_valid !== 1'b0) $display("FAIL ovr_valid_clear: got %b expected 0", key_valid); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL ovr_flag_clear: got %b expected 0", overrun); else passed++;
    $display("test_overrun done");
  endtask

  task automatic test_multi_row();
    do_reset();
    key_ready = 1'b1;
    pressed = 16'h0;
    pressed[1*4+0] = 1'b1;
    pressed[3*4+0] = 1'b1;
    for (int i = 0; i < 100 && !key_valid; i++) @(negedge clk);
    total++; if (key_valid !== 1'b1) $display("FAIL multi_valid: got %b expected 1", key_valid); else passed++;
    total++; if (key_code !== 4'h4) $display("FAIL multi_code: got %h expected 4", key_code); else passed++;
    pressed = 16'h0;
    for (int i = 0; i < 100 && key_held; i++) @(negedge clk);
    $display("test_multi_row done: code %h", key_code);
  endtask

  task automatic test_reset_in_held();
    int k_valid = -1;
    do_reset();
    key_ready = 1'b0;
    pressed = 16'h0;
    pressed[0*4+3] = 1'b1;
    for (int i = 0; i < 100 && !key_held; i++) @(negedge clk);
    total++; if (key_held !== 1'b1) $display("FAIL rh_held: got %b expected 1", key_held); else passed++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (key_valid !== 1'b0) $display("FAIL rh_valid_dropped: got %b expected 0", key_valid); else passed++;
    total++; if (key_held !== 1'b0) $display("FAIL rh_held_dropped: got %b expected 0", key_held); else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 40 && k_valid < 0; k++) begin
      @(negedge clk);
      if (key_valid) k_valid = k;
    end
    total++; if (k_valid !== 24) $display("FAIL rh_relatency: got %0d expected 24", k_valid); else passed++;
    total++; if (key_code !== 4'h3) $display("FAIL rh_code: got %h expected 3", key_code); else passed++;
    pressed = 16'h0;
    key_ready = 1'b1;
    for (int i = 0; i < 100 && key_held; i++) @(negedge clk);
    @(negedge clk);
    $display("test_reset_in_held done: valid after %0d cycles", k_valid);
  endtask

  task automatic test_random();
    int q[$];
    int key;
    int exp_code;
    do_reset();
    key_ready = 1'b1;
    for (int p = 0; p < 24; p++) begin
      key = $urandom_range(0, 15);
      pressed = 16'h0;
      pressed[key] = 1'b1;
      q.push_back(key);
      for (int i = 0; i < 85; i++) begin
        if (i == 60) pressed = 16'h0;
        @(negedge clk);
        key_ready = ($urandom_range(0, 3) != 0);
        if (key_valid && key_ready) begin
          total++;
          if (q.size() == 0) begin
            $display("FAIL rand_extra: got code %h expected no key", key_code);
          end else begin
            exp_code = q.pop_front();
            if (key_code !== exp_code[3:0]) $display("FAIL rand_code press %0d: got %h expected %h", p, key_code, exp_code[3:0]);
            else passed++;
          end
        end
      end
      $display("random press %0d key %0d", p, key);
    end
    key_ready = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (q.size() != 0) $display("FAIL rand_missing: got %0d pending expected 0", q.size()); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL rand_overrun: got %b expected 0", overrun); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_press_release();
    test_bounce();
    test_overrun();
    test_multi_row();
    test_reset_in_held();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
